// File: rtl/bubble_defs.sv
// bubble_defs: shared definitions for the result reader.
// Holds the reader FSM state encoding and the default widths of the
// data-memory word address and the word-count input.
package bubble_defs;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_CNT_W  = 10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } reader_state_t;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: rising-edge detector for a level input.
// Ports:
//   clk    - system clock, history updates on rising edge
//   reset  - asynchronous active-high reset, clears history to 0
//   in     - level input to watch
//   rise   - high while in=1 and the registered previous value is 0
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= in;
    end
  end

  // A level already high when reset releases counts as a new edge,
  // because the history restarts at 0.
  assign rise = in & ~prev;

endmodule

// File: rtl/result_reader.sv
// result_reader: once the processor raises end_signal, reads word_count
// consecutive words starting at base_addr out of data memory and streams
// them to a consumer over a valid/ready handshake, then raises done.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   end_signal   - processor program-finished level
//   base_addr    - first word address, latched at start
//   word_count   - number of words, latched at start
//   rd_en        - data-memory read strobe (one cycle per word)
//   rd_addr      - data-memory word address (always the running address)
//   rd_data      - read data, valid one cycle after rd_en is sampled
//   out_data     - streamed word
//   out_valid    - out_data holds a word not yet accepted
//   out_ready    - consumer accept
//   done         - all requested words transferred
module result_reader
  import bubble_defs::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              end_signal,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  reader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              end_rise;

  rise_detect u_end_rise (
    .clk   (clk),
    .reset (reset),
    .in    (end_signal),
    .rise  (end_rise)
  );

  assign rd_addr = addr;

  // Outputs are registered alongside the state: each transition sets the
  // output values belonging to the state being entered. The address counter
  // is ADDR_W bits wide, so incrementing past the top word wraps to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_en     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (end_rise) begin
            addr      <= base_addr;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_REQ;
              rd_en <= 1'b1;
            end
          end
        end

        S_REQ: begin
          rd_en <= 1'b0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_REQ;
              rd_en <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // Stay here while end_signal is still high so a held level
          // cannot trigger a second run.
          if (!end_signal) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed self-checking bench for result_reader.
// A synchronous data-memory model answers rd_en one cycle later; every
// expected value is a hand-written constant.
module tb_result_reader;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 10;

  logic              clk;
  logic              reset;
  logic              end_signal;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] cur_exp [0:9];

  result_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .end_signal (end_signal),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read memory: data appears the cycle after rd_en is sampled.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".rd_en"},     32'(rd_en),     32'd0);
    check_output({tag, ".rd_addr"},   32'(rd_addr),   32'd0);
    check_output({tag, ".out_data"},  out_data,       32'd0);
    check_output({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, ".done"},      32'(done),      32'd0);
  endtask

  // Caller has just raised end_signal; the next edge detects it.
  // Detect edge -> REQ, next -> WAIT, third -> OUT with out_valid high.
  // With out_ready high each later word takes exactly 3 cycles.
  // If disturb is set, a fresh end_signal edge and new base/count are
  // applied mid-run and must have no effect.
  task automatic run_stream(input string tag, input int n, input int start_addr,
                            input bit disturb);
    tick();
    check_output($sformatf("%s.first_rd_en", tag),   32'(rd_en),     32'd1);
    check_output($sformatf("%s.first_rd_addr", tag), 32'(rd_addr),   32'(start_addr));
    check_output($sformatf("%s.req_valid", tag),     32'(out_valid), 32'd0);
    tick();
    check_output($sformatf("%s.wait_rd_en", tag),    32'(rd_en),     32'd0);
    check_output($sformatf("%s.wait_valid", tag),    32'(out_valid), 32'd0);
    tick();
    check_output($sformatf("%s.w0_valid", tag), 32'(out_valid), 32'd1);
    check_output($sformatf("%s.w0_data", tag),  out_data,       cur_exp[0]);
    for (int i = 1; i < n; i++) begin
      tick();
      check_output($sformatf("%s.w%0d_rd_en", tag, i),   32'(rd_en),   32'd1);
      check_output($sformatf("%s.w%0d_rd_addr", tag, i), 32'(rd_addr),
                   32'((start_addr + i) % 1024));
      if (disturb && i == 1) begin
        end_signal = 1'b0;
        base_addr  = 10'd500;
        word_count = 10'd3;
      end
      tick();
      if (disturb && i == 1) end_signal = 1'b1;
      tick();
      check_output($sformatf("%s.w%0d_valid", tag, i), 32'(out_valid), 32'd1);
      check_output($sformatf("%s.w%0d_data", tag, i),  out_data,       cur_exp[i]);
      check_output($sformatf("%s.w%0d_done", tag, i),  32'(done),      32'd0);
    end
    tick();
    check_output($sformatf("%s.done", tag),       32'(done),      32'd1);
    check_output($sformatf("%s.end_valid", tag),  32'(out_valid), 32'd0);
    check_output($sformatf("%s.end_rd_en", tag),  32'(rd_en),     32'd0);
  endtask

  task automatic load_main_expect();
    cur_exp[0] = 32'd643; cur_exp[1] = 32'd573; cur_exp[2] = 32'd532;
    cur_exp[3] = 32'd87;  cur_exp[4] = 32'd879; cur_exp[5] = 32'd242;
    cur_exp[6] = 32'd64;  cur_exp[7] = 32'd805; cur_exp[8] = 32'd868;
    cur_exp[9] = 32'd170;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | 32'(i);
    load_main_expect();
    for (int i = 0; i < 10; i++) mem[11 + i] = cur_exp[i];
    mem[1023] = 32'd7;
    mem[0]    = 32'd9;

    reset      = 1'b0;
    end_signal = 1'b0;
    base_addr  = 10'd11;
    word_count = 10'd10;
    out_ready  = 1'b1;

    // Reset takes effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_all_zero("reset_async");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("idle_after_reset");

    // Ten-word stream, with a mid-run end_signal edge and input changes.
    end_signal = 1'b1;
    run_stream("run1", 10, 11, 1'b1);
    base_addr  = 10'd11;
    word_count = 10'd10;

    // Held end_signal after DONE must not start another run.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output($sformatf("hold_done%0d", i),  32'(done),      32'd1);
      check_output($sformatf("hold_rd_en%0d", i), 32'(rd_en),     32'd0);
      check_output($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd0);
    end
    end_signal = 1'b0;
    tick();
    check_output("done_cleared", 32'(done), 32'd0);
    end_signal = 1'b1;
    run_stream("run2", 10, 11, 1'b0);

    // Back-pressure on the first word, then reset after the third accept.
    end_signal = 1'b0;
    tick();
    out_ready  = 1'b0;
    end_signal = 1'b1;
    tick();
    tick();
    tick();
    check_output("stall_valid", 32'(out_valid), 32'd1);
    check_output("stall_data",  out_data,       32'd643);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      check_output($sformatf("stall%0d_data", i),  out_data,       32'd643);
      check_output($sformatf("stall%0d_rd_en", i), 32'(rd_en),     32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_output("accept_valid",   32'(out_valid), 32'd0);
    check_output("accept_rd_en",   32'(rd_en),     32'd1);
    check_output("accept_rd_addr", 32'(rd_addr),   32'd12);
    tick();
    tick();
    check_output("stall_w1_data", out_data, 32'd573);
    tick();
    tick();
    tick();
    check_output("stall_w2_data", out_data, 32'd532);
    tick();
    check_output("third_accept_rd_addr", 32'(rd_addr), 32'd14);
    reset = 1'b1;
    #1;
    check_all_zero("reset_midrun");
    tick();
    check_all_zero("reset_held");
    reset = 1'b0;
    run_stream("restart", 10, 11, 1'b0);

    // Zero-word request finishes at once without touching memory.
    end_signal = 1'b0;
    tick();
    word_count = 10'd0;
    end_signal = 1'b1;
    tick();
    check_output("zero_done",  32'(done),      32'd1);
    check_output("zero_rd_en", 32'(rd_en),     32'd0);
    check_output("zero_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output($sformatf("zero_rd_en%0d", i), 32'(rd_en),     32'd0);
      check_output($sformatf("zero_valid%0d", i), 32'(out_valid), 32'd0);
    end

    // Address wrap from the top word to word 0.
    end_signal = 1'b0;
    tick();
    base_addr  = 10'd1023;
    word_count = 10'd2;
    cur_exp[0] = 32'd7;
    cur_exp[1] = 32'd9;
    end_signal = 1'b1;
    run_stream("wrap", 2, 1023, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
